vedic_dot_acc: RTL and testbench

//  Sequential accumulator placed directly downstream of vedic_32x32. Sums a programmed number of unsigned
//  64-bit products into a wide accumulator, forming a dot product, and presents the result over a

---
 rtl/vedic_dot_acc_pkg.sv | 16 +
 rtl/vedic_dot_acc_add_nbit.sv | 32 +++
 rtl/vedic_dot_acc.sv | 102 ++++++++++
 tb/tb_vedic_dot_acc.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/vedic_dot_acc_pkg.sv
// Shared definitions for the dot-product accumulator and the multiplier wrapper.
// Holds the FSM state encoding and the default product/accumulator/count widths
// so that every block downstream of vedic_32x32 agrees on them.
package vedic_dot_acc_pkg;

  localparam int unsigned PROD_W_DEF = 64;
  localparam int unsigned ACC_W_DEF  = 72;
  localparam int unsigned LEN_W_DEF  = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/vedic_dot_acc_add_nbit.sv
// add_nbit: parameterised N-bit ripple-carry adder.
// Bit 0 is a half adder (no carry in); the remaining bits are full adders.
// Ports:
//   a, b       in   N   addends
//   sum        out  N   a + b mod 2^N
//   carry_out  out  1   carry out of the top bit
module add_nbit #(
  parameter int unsigned N = 72
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         carry_out
);

  logic [N:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_bit
    if (i == 0) begin : g_half
      assign sum[i]     = a[i] ^ b[i];
      assign carry[i+1] = a[i] & b[i];
    end else begin : g_full
      assign sum[i]     = a[i] ^ b[i] ^ carry[i];
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign carry_out = carry[N];

endmodule

// File: rtl/vedic_dot_acc.sv
// vedic_dot_acc: sums a programmed number of unsigned products from vedic_32x32
// into a wide accumulator and presents the dot product over valid/ready.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, len            begin a job of len terms (sampled only when idle)
//   prod_valid/prod_ready term handshake; product is the term value
//   acc_out/acc_valid     result, held while acc_valid=1
//   acc_ready             downstream consumes the result
//   busy                  job in progress or result pending
//   ovf                   sticky carry-out of the accumulator for the current job
module vedic_dot_acc
  import vedic_dot_acc_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] product,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              busy,
  output logic              ovf
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;

  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   add_sum;
  logic               add_co;

  assign prod_ext = ACC_W'(product);

  add_nbit #(
    .N(ACC_W)
  ) u_add (
    .a         (acc_q),
    .b         (prod_ext),
    .sum       (add_sum),
    .carry_out (add_co)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          cnt_d = len;
          // A zero-length job completes immediately with a zero result.
          state_d = (len == '0) ? StDone : StAccum;
        end
      end
      StAccum: begin
        if (prod_valid) begin
          acc_d = add_sum;
          ovf_d = ovf_q | add_co;
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = StDone;
        end
      end
      StDone: begin
        if (acc_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign prod_ready = (state_q == StAccum);
  assign acc_valid  = (state_q == StDone);
  assign busy       = (state_q == StAccum) || (state_q == StDone);
  assign acc_out    = acc_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_vedic_dot_acc.sv
// Self-checking bench for vedic_dot_acc: two instances (72-bit and 66-bit
// accumulators) share the same stimulus and are compared every cycle against a
// reference that keeps the exact mathematical sum of accepted terms.
module tb_vedic_dot_acc;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [7:0]   len;
  logic         prod_valid;
  logic [63:0]  product;
  logic         acc_ready;

  logic         prod_ready, prod_ready66;
  logic [71:0]  acc_out;
  logic [65:0]  acc_out66;
  logic         acc_valid, acc_valid66;
  logic         busy, busy66;
  logic         ovf, ovf66;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  vedic_dot_acc #(.PROD_W(64), .ACC_W(72), .LEN_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .product    (product),
    .acc_out    (acc_out),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .busy       (busy),
    .ovf        (ovf)
  );

  vedic_dot_acc #(.PROD_W(64), .ACC_W(66), .LEN_W(8)) dut66 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready66),
    .product    (product),
    .acc_out    (acc_out66),
    .acc_valid  (acc_valid66),
    .acc_ready  (acc_ready),
    .busy       (busy66),
    .ovf        (ovf66)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: job phase, terms still owed, and the exact (unwrapped) sum.
  int           m_phase;  // 0 waiting for a job, 1 collecting terms, 2 result offered
  int           m_left;
  logic [127:0] m_sum;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_left  = 0;
      m_sum   = '0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_sum  = '0;
          m_left = int'(len);
          m_phase = (len == 0) ? 2 : 1;
        end
        1: if (prod_valid) begin
          m_sum  = m_sum + {64'd0, product};
          m_left = m_left - 1;
          if (m_left == 0) m_phase = 2;
        end
        default: if (acc_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("prod_ready", {127'd0, prod_ready}, {127'd0, m_phase == 1});
    chk("acc_valid", {127'd0, acc_valid}, {127'd0, m_phase == 2});
    chk("busy", {127'd0, busy}, {127'd0, m_phase != 0});
    chk("acc_out", {56'd0, acc_out}, {56'd0, m_sum[71:0]});
    chk("ovf", {127'd0, ovf}, {127'd0, m_sum[127:72] != 0});
    chk("acc_valid66", {127'd0, acc_valid66}, {127'd0, m_phase == 2});
    chk("acc_out66", {62'd0, acc_out66}, {62'd0, m_sum[65:0]});
    chk("ovf66", {127'd0, ovf66}, {127'd0, m_sum[127:66] != 0});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_job(input logic [7:0] n);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
    len   = $urandom_range(0, 255);
  endtask

  task automatic drive_term(input logic [63:0] p, input int idle);
    logic took;
    took = 1'b0;
    prod_valid = 1'b0;
    product    = {$urandom, $urandom};
    repeat (idle) tick();
    product    = p;
    prod_valid = 1'b1;
    for (int i = 0; i < 50 && !took; i++) begin
      took = prod_ready;
      tick();
    end
    prod_valid = 1'b0;
    if (!took) chk("term_accept_timeout", 128'd0, 128'd1);
  endtask

  task automatic wait_valid();
    int i;
    for (i = 0; i < 300 && !acc_valid; i++) tick();
    if (!acc_valid) chk("acc_valid_timeout", 128'd0, 128'd1);
  endtask

  // Hold the result for 'hold' cycles, optionally poking start, then consume it.
  task automatic release_result(input int hold, input bit poke);
    acc_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      start = poke && (i == 1);
      len   = 8'd3;
      tick();
    end
    start     = 1'b0;
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
  endtask

  function automatic logic [63:0] rand_prod(input int ones_pct);
    if ($urandom_range(0, 99) < ones_pct) return 64'hFFFF_FFFF_FFFF_FFFF;
    return {$urandom, $urandom};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] t2 [3];
    rst_n = 1'b0; start = 1'b0; len = '0; prod_valid = 1'b0; product = '0; acc_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset mid-job after 2 of 4 terms: everything clears, no result offered.
    begin_job(8'd4);
    drive_term(64'd100, 0);
    drive_term(64'd200, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_acc_out", {56'd0, acc_out}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_ovf", {127'd0, ovf}, 128'd0);
    chk("rst_acc_valid", {127'd0, acc_valid}, 128'd0);
    chk("rst_prod_ready", {127'd0, prod_ready}, 128'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_acc_valid", {127'd0, acc_valid}, 128'd0);

    // Basic three-term dot product.
    t2[0] = 64'd6; t2[1] = 64'hFFFF_FFFF_0000_0001; t2[2] = 64'd10;
    begin_job(8'd3);
    for (int i = 0; i < 3; i++) drive_term(t2[i], 0);
    chk("basic_valid_after_last", {127'd0, acc_valid}, 128'd1);
    chk("basic_acc_out", {56'd0, acc_out}, 128'h0_FFFF_FFFF_0000_0011);
    chk("basic_ovf", {127'd0, ovf}, 128'd0);
    release_result(1, 1'b0);

    // Stalls: valid pattern 1,0,0,1 over two terms.
    begin_job(8'd2);
    drive_term(64'd7, 0);
    chk("stall_not_done", {127'd0, acc_valid}, 128'd0);
    drive_term(64'd9, 2);
    chk("stall_acc_out", {56'd0, acc_out}, 128'd16);
    release_result(2, 1'b0);

    // Zero-length job.
    begin_job(8'd0);
    chk("len0_valid", {127'd0, acc_valid}, 128'd1);
    chk("len0_acc_out", {56'd0, acc_out}, 128'd0);
    chk("len0_prod_ready", {127'd0, prod_ready}, 128'd0);
    release_result(1, 1'b0);

    // Overflow of the 66-bit instance, then backpressure with an ignored start.
    begin_job(8'd5);
    for (int i = 0; i < 5; i++) drive_term(64'hFFFF_FFFF_FFFF_FFFF, 0);
    chk("ovf66_acc_out", {62'd0, acc_out66}, 128'hFFFF_FFFF_FFFF_FFFB);
    chk("ovf66_flag", {127'd0, ovf66}, 128'd1);
    chk("ovf72_flag", {127'd0, ovf}, 128'd0);
    release_result(5, 1'b1);
    chk("after_release_idle", {127'd0, busy}, 128'd0);
    chk("ovf66_held_in_idle", {127'd0, ovf66}, 128'd1);
    begin_job(8'd1);
    chk("restart_clears_ovf", {127'd0, ovf66}, 128'd0);
    drive_term(64'd42, 0);
    chk("restart_acc_out", {56'd0, acc_out}, 128'd42);
    release_result(0, 1'b0);

    // Randomised jobs, back to back.
    for (int j = 0; j < 40; j++) begin
      begin_job(8'($urandom_range(0, 12)));
      for (int k = 0; k < 300 && prod_ready; k++)
        drive_term(rand_prod(30), $urandom_range(0, 2));
      wait_valid();
      release_result($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
